// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared register map, CTRL layout and byte-lane merge helper
// for the LED PWM Avalon-MM slave.
//   ADDR_*          word addresses of the register file
//   CTRL_*_BIT      bit positions inside CTRL
//   ctrl_t          packed CTRL register {invert, enable}
//   be_merge()      applies Avalon byte enables to a 32-bit register image
package led_pwm_pkg;

    localparam int ADDR_CTRL      = 0;
    localparam int ADDR_PERIOD    = 1;
    localparam int ADDR_STATUS    = 2;
    localparam int ADDR_IRQ_MASK  = 3;
    localparam int ADDR_DUTY_BASE = 8;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_INVERT_BIT = 1;

    typedef struct packed {
        logic invert;
        logic enable;
    } ctrl_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/led_pwm_avmm_slave_core.sv
// led_pwm_core: period counter, shadow-to-active transfer and per-channel
// duty comparators.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   ctrl_i          ENABLE / INVERT
//   period_i        shadow PERIOD
//   duty_i          shadow DUTY per channel
//   pwm_o           registered PWM outputs, INVERT applied
//   wrap_o          high in the cycle the counter wraps while enabled
module led_pwm_core
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH = 18,
    parameter int CNT_W  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  ctrl_t                          ctrl_i,
    input  logic [CNT_W-1:0]               period_i,
    input  logic [NUM_CH-1:0][CNT_W-1:0]   duty_i,
    output logic [NUM_CH-1:0]              pwm_o,
    output logic                           wrap_o
);

    logic [CNT_W-1:0]             cnt_q, cnt_d, period_act_q;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q;
    logic [NUM_CH-1:0]            pwm_raw_q, pwm_raw_d;
    logic                         load;

    // While disabled the active copies follow the shadows every cycle, so
    // enabling always begins a clean period with the latest values.
    always_comb begin
        wrap_o    = ctrl_i.enable && (cnt_q == period_act_q);
        load      = !ctrl_i.enable || wrap_o;
        cnt_d     = load ? '0 : cnt_q + CNT_W'(1);
        pwm_raw_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            pwm_raw_d[i] = ctrl_i.enable && (cnt_q < duty_act_q[i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            pwm_raw_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pwm_raw_q <= pwm_raw_d;
            if (load) begin
                period_act_q <= period_i;
                duty_act_q   <= duty_i;
            end
        end
    end

    assign pwm_o = pwm_raw_q ^ {NUM_CH{ctrl_i.invert}};

endmodule

// File: rtl/led_pwm_avmm_slave.sv
// led_pwm_avmm_slave: Avalon-MM PWM peripheral driving the board LEDs with
// double-buffered period/duty registers.
//   clk, reset_n                 clock, asynchronous active-low reset
//   avs_address/read/write       word address and strobes (zero wait states)
//   avs_writedata/byteenable     write data and byte lanes
//   avs_readdata/readdatavalid   read response, fixed latency 1
//   pwm_out                      LED drive, bit i = channel i
//   irq                          period-wrap interrupt
// Optional: define LED_PWM_IRQ_EN to build STATUS.WRAP, IRQ_MASK and irq;
// otherwise those registers read 0 and irq is tied low.
module led_pwm_avmm_slave
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH = 18,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    ctrl_t                        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]             period_q, period_d;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_q, duty_d;
    logic [31:0]                  rd_mux, readdata_q, readdata_d;
    logic                         readdatavalid_q;
    logic                         wrap;

`ifdef LED_PWM_IRQ_EN
    logic wrap_q, wrap_d, irq_mask_q, irq_mask_d, irq_q;
`endif

    function automatic logic is_addr(input logic [ADDR_W-1:0] addr, input int a);
        return addr == ADDR_W'(a);
    endfunction

    // Reads sample the shadow registers before this cycle's write lands, so a
    // simultaneous read and write returns pre-write data.
    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        duty_d   = duty_q;
        rd_mux   = '0;
        if (avs_write && is_addr(avs_address, ADDR_CTRL))
            ctrl_d = ctrl_t'(2'(be_merge(32'(ctrl_q), avs_writedata, avs_byteenable)));
        if (avs_write && is_addr(avs_address, ADDR_PERIOD))
            period_d = CNT_W'(be_merge(32'(period_q), avs_writedata, avs_byteenable));
        if (is_addr(avs_address, ADDR_CTRL)) begin
            rd_mux[CTRL_ENABLE_BIT] = ctrl_q.enable;
            rd_mux[CTRL_INVERT_BIT] = ctrl_q.invert;
        end
        if (is_addr(avs_address, ADDR_PERIOD))
            rd_mux = 32'(period_q);
        for (int i = 0; i < NUM_CH; i++) begin
            if (is_addr(avs_address, ADDR_DUTY_BASE + i)) begin
                rd_mux = 32'(duty_q[i]);
                if (avs_write)
                    duty_d[i] = CNT_W'(be_merge(32'(duty_q[i]), avs_writedata, avs_byteenable));
            end
        end
`ifdef LED_PWM_IRQ_EN
        if (is_addr(avs_address, ADDR_STATUS))
            rd_mux = {31'b0, wrap_q};
        if (is_addr(avs_address, ADDR_IRQ_MASK))
            rd_mux = {31'b0, irq_mask_q};
`endif
        readdata_d = avs_read ? rd_mux : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q          <= '0;
            period_q        <= '0;
            duty_q          <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            ctrl_q          <= ctrl_d;
            period_q        <= period_d;
            duty_q          <= duty_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= avs_read;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;

    led_pwm_core #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .ctrl_i   (ctrl_q),
        .period_i (period_q),
        .duty_i   (duty_q),
        .pwm_o    (pwm_out),
        .wrap_o   (wrap)
    );

`ifdef LED_PWM_IRQ_EN
    // A wrap in the same cycle as a write-1-to-clear keeps WRAP set.
    always_comb begin
        irq_mask_d = irq_mask_q;
        wrap_d     = wrap_q;
        if (avs_write && avs_byteenable[0] && is_addr(avs_address, ADDR_IRQ_MASK))
            irq_mask_d = avs_writedata[0];
        if (avs_write && avs_byteenable[0] && avs_writedata[0] && is_addr(avs_address, ADDR_STATUS))
            wrap_d = 1'b0;
        if (wrap)
            wrap_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q     <= 1'b0;
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            irq_mask_q <= irq_mask_d;
            irq_q      <= wrap_q & irq_mask_q;
        end
    end

    assign irq = irq_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
    assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_led_pwm_avmm_slave.sv
// tb_led_pwm_avmm_slave: directed self-checking bench for led_pwm_avmm_slave.
module tb_led_pwm_avmm_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [17:0] pwm_out;
    logic        irq;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pwm_avmm_slave dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .pwm_out           (pwm_out),
        .irq               (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        check({tag, "_vld"}, 32'(avs_readdatavalid), 32'd1);
        check(tag, avs_readdata, exp);
    endtask

    task automatic cap(input int n, input int ch, output logic [31:0] v);
        v = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v[k] = pwm_out[ch];
        end
    endtask

    task automatic cnt_hi(input int n, input int ch, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c += int'(pwm_out[ch]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int c, c1, c2;

        repeat (3) @(negedge clk);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_vld", 32'(avs_readdatavalid), 32'd0);
        check("reset_rdata", avs_readdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // register access and byte lanes
        wr(5'd1, 32'h0000_1234, 4'b0001);
        rd(5'd1, "period_lane0", 32'h34);
        @(negedge clk);
        check("vld_drop", 32'(avs_readdatavalid), 32'd0);
        check("rdata_idle", avs_readdata, 32'd0);
        wr(5'd1, 32'h0000_AB00, 4'b0010);
        rd(5'd1, "period_lane1", 32'hAB34);
        wr(5'd1, 32'hFFFF_FFFF);
        rd(5'd1, "period_width", 32'hFFFF);
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, "ctrl_width", 32'h3);
        wr(5'd0, 32'h0);
        wr(5'd4, 32'hDEAD_BEEF);
        rd(5'd4, "unmapped4", 32'h0);
        wr(5'd25, 32'h0001_BEEF);
        rd(5'd25, "duty17", 32'hBEEF);
        wr(5'd26, 32'hFFFF);
        rd(5'd26, "duty_oob", 32'h0);
        rd(5'd31, "addr31", 32'h0);

        // simultaneous read and write returns pre-write data
        avs_address = 5'd1;
        avs_writedata = 32'h55;
        avs_byteenable = 4'hF;
        avs_read = 1'b1;
        avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        avs_write = 1'b0;
        check("rw_old", avs_readdata, 32'hFFFF);
        rd(5'd1, "rw_new", 32'h55);

`ifdef LED_PWM_IRQ_EN
        wr(5'd3, 32'h1);
        rd(5'd3, "mask_rd", 32'h1);
        wr(5'd3, 32'h0);
        rd(5'd2, "status_idle", 32'h0);
`else
        wr(5'd3, 32'h1);
        rd(5'd3, "mask_off", 32'h0);
        wr(5'd2, 32'h1);
        rd(5'd2, "status_off", 32'h0);
`endif

        // basic PWM: period 10 cycles, ch0 3 high, ch1 off, ch2 full on
        wr(5'd1, 32'd9);
        wr(5'd8, 32'd3);
        wr(5'd9, 32'd0);
        wr(5'd10, 32'd12);
        wr(5'd0, 32'h1);
        cap(20, 0, v);
        check("basic_phase", v, 32'h0001_C07);
        cnt_hi(100, 0, c);
        check("basic_ch0", 32'(c), 32'd30);
        cnt_hi(100, 1, c1);
        check("basic_ch1", 32'(c1), 32'd0);
        cnt_hi(100, 2, c2);
        check("basic_ch2", 32'(c2), 32'd100);
`ifndef LED_PWM_IRQ_EN
        c = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            c += int'(irq);
        end
        check("irq_tied", 32'(c), 32'd0);
`endif

        // glitch-free duty update: write DUTY0=20 while cnt==30
        wr(5'd0, 32'h0);
        wr(5'd1, 32'd99);
        wr(5'd8, 32'd50);
        wr(5'd0, 32'h1);
        c = 0;
        c1 = 0;
        avs_address = 5'd8;
        avs_writedata = 32'd20;
        avs_byteenable = 4'hF;
        for (int k = 0; k < 200; k++) begin
            avs_write = (k == 30);
            @(negedge clk);
            if (k < 100) c += int'(pwm_out[0]);
            else c1 += int'(pwm_out[0]);
        end
        avs_write = 1'b0;
        check("glitch_cur", 32'(c), 32'd50);
        check("glitch_next", 32'(c1), 32'd20);

        // invert while disabled, then inverted PWM with duty == period
        wr(5'd0, 32'h2);
        @(negedge clk);
        check("invert_idle", 32'(pwm_out), 32'h3FFFF);
        cnt_hi(20, 0, c);
        check("invert_hold", 32'(c), 32'd20);
        wr(5'd8, 32'd4);
        wr(5'd1, 32'd4);
        wr(5'd0, 32'h3);
        cap(10, 0, v);
        check("invert_pwm", v, 32'h210);

        // asynchronous reset in the middle of a read response
        avs_address = 5'd0;
        avs_read = 1'b1;
        @(posedge clk);
        #2;
        check("rst_pre_vld", 32'(avs_readdatavalid), 32'd1);
        check("rst_pre_pwm1", 32'(pwm_out[1]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_vld", 32'(avs_readdatavalid), 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        avs_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(5'd0, "rst_ctrl", 32'h0);
        rd(5'd1, "rst_period", 32'h0);
        rd(5'd8, "rst_duty0", 32'h0);

        // restart after reset begins from cnt 0
        wr(5'd1, 32'd9);
        wr(5'd8, 32'd3);
        wr(5'd0, 32'h1);
        cap(20, 0, v);
        check("restart_phase", v, 32'h0001_C07);

`ifdef LED_PWM_IRQ_EN
        // wraps at cnt 3; clears at a quiet cycle and on a wrap cycle
        wr(5'd0, 32'h0);
        wr(5'd2, 32'h1);
        wr(5'd3, 32'h1);
        wr(5'd1, 32'd3);
        wr(5'd0, 32'h1);
        v = '0;
        avs_address = 5'd2;
        avs_writedata = 32'h1;
        avs_byteenable = 4'hF;
        for (int k = 0; k < 16; k++) begin
            avs_write = (k == 4 || k == 11);
            @(negedge clk);
            v[k] = irq;
        end
        avs_write = 1'b0;
        check("irq_seq", v, 32'hFF10);
        rd(5'd2, "status_wrap", 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
